// File: rtl/datapath_pkg.sv
// Shared datapath constants: default bus width and the OUT opcode used by the
// control unit and benches.
package datapath_pkg;

    localparam int unsigned DP_DATA_WIDTH = 32;

    localparam logic [4:0] OPC_OUT = 5'b10111;

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the output-port FIFO: synchronous write,
// combinational read, no reset.
module fifo_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [PTR_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/out_port_fifo.sv
// Buffered output port: bus pushes into a FWFT FIFO drained by a device over
// valid/ready, with a legacy last-value register and sticky overflow flag.
module out_port_fifo
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DP_DATA_WIDTH,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned PTR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  out_port_enable,
    input  logic [DATA_WIDTH-1:0] bus_data,
    output logic                  port_full,
    output logic                  port_empty,
    output logic [PTR_W:0]        count,
    output logic                  dev_valid,
    output logic [DATA_WIDTH-1:0] dev_data,
    input  logic                  dev_ready,
    output logic [DATA_WIDTH-1:0] out_port_q,
    output logic                  overflow_err,
    input  logic                  err_clear
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;
    logic [DATA_WIDTH-1:0] r_out_q;
    logic                  r_ovf;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic [PTR_W:0]        w_count_d;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign port_empty = (r_count == '0);
    assign port_full  = (r_count == FULL_CNT);
    assign dev_valid  = ~port_empty;
    assign count      = r_count;

    assign w_pop  = dev_valid & dev_ready;
    // When full, the pop frees the slot at rd_ptr == wr_ptr for the incoming word.
    assign w_push = out_port_enable & (~port_full | w_pop);
    assign w_drop = out_port_enable & port_full & ~w_pop;

    always_comb begin
        w_count_d = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CNT_ONE;
            2'b01:   w_count_d = r_count - CNT_ONE;
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_out_q  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_count <= w_count_d;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                r_out_q  <= bus_data;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            // A new overflow takes priority over a clear in the same cycle.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (err_clear) begin
                r_ovf <= 1'b0;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Masked so unwritten slots never reach the device.
    assign dev_data     = dev_valid ? w_rdata : '0;
    assign out_port_q   = r_out_q;
    assign overflow_err = r_ovf;

endmodule
